// File: rtl/mmio_uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Defining MMIO_UART_TX_PARITY_EN adds the PARITY state to tx_state_t.
package mmio_uart_pkg;

`ifdef MMIO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

  // Register select is dmem_address[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_EMPTY  = 2;
  localparam int STAT_OVF    = 3;
  localparam int STAT_CNT_LO = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic [31:0] format_load(input logic [2:0] funct3,
                                              input logic [31:0] word);
    case (funct3)
      F3_LB:   return {{24{word[7]}}, word[7:0]};
      F3_LH:   return {{16{word[15]}}, word[15:0]};
      F3_LBU:  return {24'b0, word[7:0]};
      F3_LHU:  return {16'b0, word[15:0]};
      F3_LW:   return word;
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; DEPTH must be a power of 2 so
// the pointers wrap naturally. A push while full is dropped unless a pop
// happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array has no reset; pointers and count alone define
  // which entries are valid, so a flushed FIFO never exposes stale data.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: registers use <= so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and registered loads.
// Define MMIO_UART_TX_PARITY_EN for a parity bit selectable via CTRL bit1.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_3000,
  parameter int          CLKS_PER_BIT = 104,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  funct3,
  input  logic        dmem_wren,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_data_in,
  output logic [31:0] dmem_data_out,
  output logic        tx
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  logic          hit;
  logic [1:0]    reg_sel;
  logic          wr_en;
  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          enable;
  logic [31:0]   count_ext;
  logic [3:0]    cnt_sat;
  logic [31:0]   status_word;
  logic [31:0]   ctrl_word;
  logic [31:0]   rd_word;
  tx_state_t     state;
  logic [BW-1:0] baud_cnt;
  logic          baud_last;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          unused_bits;
`ifdef MMIO_UART_TX_PARITY_EN
  logic          odd_parity;
  logic          parity_bit;
`endif

  assign hit         = (dmem_address[31:4] == BASE_ADDR[31:4]);
  assign reg_sel     = dmem_address[3:2];
  assign wr_en       = dmem_wren && hit;
  assign fifo_push   = wr_en && (reg_sel == REG_TXDATA);
  assign fifo_pop    = (state == IDLE) && enable && !fifo_empty;
  assign baud_last   = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign unused_bits = ^{dmem_data_in[31:8], dmem_address[1:0]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (dmem_data_in[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: every always_comb output is given a default first, so no path
  // through the block can infer a latch.
  always_comb begin
    count_ext   = 32'(fifo_count);
    cnt_sat     = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
    status_word = '0;
    status_word[STAT_BUSY]          = (state != IDLE);
    status_word[STAT_FULL]          = fifo_full;
    status_word[STAT_EMPTY]         = fifo_empty;
    status_word[STAT_OVF]           = overflow;
    status_word[STAT_CNT_LO +: 4]   = cnt_sat;
`ifdef MMIO_UART_TX_PARITY_EN
    ctrl_word = {30'b0, odd_parity, enable};
`else
    ctrl_word = {31'b0, enable};
`endif
    case (reg_sel)
      REG_STATUS: rd_word = status_word;
      REG_CTRL:   rd_word = ctrl_word;
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) dmem_data_out <= '0;
    else       dmem_data_out <= hit ? format_load(funct3, rd_word) : '0;
  end

  // A push+pop on a full FIFO succeeds, so only an unmatched push overflows
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      enable     <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
      odd_parity <= 1'b0;
`endif
    end else begin
      if (fifo_push && fifo_full && !fifo_pop)
        overflow <= 1'b1;
      else if (wr_en && (reg_sel == REG_STATUS) && dmem_data_in[STAT_OVF])
        overflow <= 1'b0;
      if (wr_en && (reg_sel == REG_CTRL)) begin
        enable     <= dmem_data_in[0];
`ifdef MMIO_UART_TX_PARITY_EN
        odd_parity <= dmem_data_in[1];
`endif
      end
    end
  end

  // tx is driven from the same flop block as the state, one bit per CLKS_PER_BIT
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tx         <= 1'b1;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
`ifdef MMIO_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (fifo_pop) begin
            shift <= fifo_dout;
            state <= START;
            tx    <= 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
            parity_bit <= (^fifo_dout) ^ odd_parity;
`endif
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
`ifdef MMIO_UART_TX_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
`endif
        STOP: begin
          tx <= 1'b1;
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: loads and serial frames are checked by
// independent monitors against expectation queues filled by the stimulus.
module tb_mmio_uart_tx;
  import mmio_uart_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam logic [2:0]  SB    = 3'b000;
  localparam logic [2:0]  SW    = 3'b010;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_S = NBITS * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  funct3 = 3'b0;
  logic        dmem_wren = 1'b0;
  logic [31:0] dmem_address = 32'b0;
  logic [31:0] dmem_data_in = 32'b0;
  logic [31:0] dmem_data_out;
  logic        tx;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .funct3        (funct3),
    .dmem_wren     (dmem_wren),
    .dmem_address  (dmem_address),
    .dmem_data_in  (dmem_data_in),
    .dmem_data_out (dmem_data_out),
    .tx            (tx)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] exp_rd_q[$];
  string       exp_rd_name_q[$];
  logic [7:0]  exp_tx_q[$];
  int          exp_gap_q[$];
  logic        exp_par_q[$];
  logic        rd_strobe = 1'b0;
  logic        rd_seen   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Bus tasks start and end on a falling edge; each occupies one clock.
  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    dmem_address = addr;
    dmem_data_in = data;
    funct3       = f3;
    dmem_wren    = 1'b1;
    rd_strobe    = 1'b0;
    @(negedge clk);
    dmem_wren    = 1'b0;
  endtask

  task automatic load(input logic [31:0] addr, input logic [2:0] f3,
                      input logic [31:0] exp, input string name);
    exp_rd_q.push_back(exp);
    exp_rd_name_q.push_back(name);
    dmem_address = addr;
    funct3       = f3;
    dmem_wren    = 1'b0;
    rd_strobe    = 1'b1;
    @(negedge clk);
    rd_strobe    = 1'b0;
  endtask

  task automatic idle(input int n);
    dmem_wren = 1'b0;
    rd_strobe = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_frame(input logic [7:0] b, input int gap, input logic par);
    exp_tx_q.push_back(b);
    exp_gap_q.push_back(gap);
    exp_par_q.push_back(par);
  endtask

  task automatic wait_tx_drain(input int max_cycles);
    int n = 0;
    while (exp_tx_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("tx_drain_timeout", exp_tx_q.size(), 0);
  endtask

  // Load monitor: data is valid on the falling edge after the sampling edge
  always @(posedge clk) rd_seen <= rd_strobe;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_rd_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL load_unexpected: got=%h expected=none", dmem_data_out);
      end else begin
        check(exp_rd_name_q.pop_front(), dmem_data_out, exp_rd_q.pop_front());
      end
    end
  end

  // Serial monitor: clock-accurate receiver sampling every falling edge
  logic       rx_active = 1'b0;
  int         rx_idx = 0;
  logic [7:0] rx_byte = 8'b0;
  logic       rx_par = 1'b0;
  logic       rx_ok = 1'b1;
  int         rx_gap = 0;
  int         gap_cnt = 0;
  int         bit_no;
  int         pos;
  logic [7:0] e_byte;
  int         e_gap;
  logic       e_par;

  always @(negedge clk) begin
    if (reset) begin
      rx_active = 1'b0;
      gap_cnt   = 0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1'b1;
        rx_idx    = 1;
        rx_ok     = 1'b1;
        rx_byte   = 8'b0;
        rx_par    = 1'b0;
        rx_gap    = gap_cnt;
      end else begin
        gap_cnt++;
      end
    end else begin
      bit_no = rx_idx / CPB;
      pos    = rx_idx % CPB;
      if (bit_no == 0) begin
        if (tx !== 1'b0) rx_ok = 1'b0;
      end else if (bit_no <= 8) begin
        if (pos == 0) rx_byte[bit_no-1] = tx;
        else if (tx !== rx_byte[bit_no-1]) rx_ok = 1'b0;
      end else if (bit_no == NBITS - 1) begin
        if (tx !== 1'b1) rx_ok = 1'b0;
      end else begin
        if (pos == 0) rx_par = tx;
        else if (tx !== rx_par) rx_ok = 1'b0;
      end
      rx_idx++;
      if (rx_idx == FRAME_S) begin
        rx_active = 1'b0;
        gap_cnt   = 0;
        if (exp_tx_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL tx_unexpected_frame: got=%h expected=none", rx_byte);
        end else begin
          e_byte = exp_tx_q.pop_front();
          e_gap  = exp_gap_q.pop_front();
          e_par  = exp_par_q.pop_front();
          check("tx_byte", rx_byte, e_byte);
          check("tx_framing", rx_ok, 1);
          if (e_gap >= 0) check("tx_gap", rx_gap, e_gap);
`ifdef MMIO_UART_TX_PARITY_EN
          check("tx_parity", rx_par, e_par);
`endif
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset_tx", tx, 1);
    load(BASE + 32'h4, F3_LW, 32'h4, "status_after_reset");
    load(BASE + 32'h8, F3_LW, 32'h1, "ctrl_after_reset");
    load(BASE + 32'h0, F3_LW, 32'h0, "txdata_reads_zero");

    // One frame of 0x55; STATUS polled every clock to time the busy window
    expect_frame(8'h55, -1, 1'b0);
    store(BASE, 32'h55, SW);
    load(BASE + 32'h4, F3_LW, 32'h10, "status_queued");
    for (int i = 0; i < FRAME_S; i++) load(BASE + 32'h4, F3_LW, 32'h5, "status_busy");
    load(BASE + 32'h4, F3_LW, 32'h4, "status_idle_after_frame");
    wait_tx_drain(100);

    // Fill past capacity with the transmitter disabled
    store(BASE + 32'h8, 32'h0, SW);
    for (int i = 1; i <= 9; i++) store(BASE, 32'(i), SB);
    load(BASE + 32'h4, F3_LW,  32'h0000_008A, "status_full_overflow");
    load(BASE + 32'h4, F3_LB,  32'hFFFF_FF8A, "status_lb_sext");
    load(BASE + 32'h4, F3_LBU, 32'h0000_008A, "status_lbu_zext");
    load(BASE + 32'h4, F3_LH,  32'h0000_008A, "status_lh");
    store(BASE + 32'h40, 32'hAB, SW);
    load(BASE + 32'h40, F3_LW, 32'h0, "miss_reads_zero");
    load(BASE + 32'h4, F3_LW,  32'h0000_008A, "status_after_miss");

    // Re-enable: eight back-to-back frames with one idle clock between them
    for (int i = 1; i <= 8; i++) begin
      logic [7:0] b;
      b = 8'(i);
      expect_frame(b, (i == 1) ? -1 : 1, ^b);
    end
    store(BASE + 32'h8, 32'h1, SW);
    wait_tx_drain(8 * (FRAME_S + 1) + 50);
    idle(FRAME_S + 10);
    load(BASE + 32'h4, F3_LW, 32'hC, "status_drained_overflow");
    store(BASE + 32'h4, 32'h8, SW);
    load(BASE + 32'h4, F3_LW, 32'h4, "status_overflow_cleared");

    // Reset ten clocks into a frame with another byte still queued
    store(BASE, 32'hC3, SW);
    store(BASE, 32'h5A, SW);
    idle(10);
    reset = 1'b1;
    @(posedge clk);
    #1 check("reset_mid_frame_tx", tx, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    load(BASE + 32'h4, F3_LW, 32'h4, "status_after_mid_reset");
    idle(2 * FRAME_S);

`ifdef MMIO_UART_TX_PARITY_EN
    store(BASE + 32'h8, 32'h3, SW);
    load(BASE + 32'h8, F3_LW, 32'h3, "ctrl_odd_readback");
    expect_frame(8'h07, -1, 1'b0);
    store(BASE, 32'h07, SW);
    wait_tx_drain(FRAME_S + 20);
    store(BASE + 32'h8, 32'h1, SW);
    expect_frame(8'h07, -1, 1'b1);
    store(BASE, 32'h07, SW);
    wait_tx_drain(FRAME_S + 20);
`else
    store(BASE + 32'h8, 32'h3, SW);
    load(BASE + 32'h8, F3_LW, 32'h1, "ctrl_bit1_ignored");
`endif

    idle(5);
    check("tx_queue_empty", exp_tx_q.size(), 0);
    check("rd_queue_empty", exp_rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
